// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared types and constants for the RV32M decode/execute slice.
//   decode_execute_t   control word from RV32M decode (op select, signedness,
//                      lower_word, start)
//   rv32m_exec_state_t execute-unit FSM states
//   rv32m_special_t    divide special cases resolved at accept
package rv32m_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned RV32M_ITERATIONS = 32;
  localparam int unsigned CNT_W            = 6;

  typedef enum logic [1:0] {
    sign_sign   = 2'd0,
    sign_usign  = 2'd1,
    usign_usign = 2'd2
  } rv32m_signedness_t;

  typedef struct packed {
    logic              mul;
    logic              div;
    logic              rem;
    rv32m_signedness_t signedness;
    logic              lower_word;
    logic              start;
  } decode_execute_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    DIV   = 3'd2,
    FIXUP = 3'd3,
    DONE  = 3'd4
  } rv32m_exec_state_t;

  typedef enum logic [1:0] {
    SPECIAL_NONE     = 2'd0,
    SPECIAL_DIV_ZERO = 2'd1,
    SPECIAL_OVERFLOW = 2'd2
  } rv32m_special_t;

endpackage

// File: rtl/rv32m_radix2_divider.sv
// rv32m_radix2_divider: one combinational restoring-divide step on magnitudes.
//   rem_i/quo_i   partial remainder / quotient (quo_i still holds the
//                 unconsumed dividend bits in its upper end)
//   divisor_i     divisor magnitude
//   rem_o/quo_o   partial remainder / quotient after this step
module rv32m_radix2_divider
  import rv32m_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;

  // Shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    shifted = {rem_i, quo_i[XLEN-1]};
    diff    = {1'b0, shifted} - {2'b00, divisor_i};
    if (diff[XLEN+1]) begin
      // Borrow implies shifted < divisor, so it fits in XLEN bits.
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end else begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/rv32m_execute.sv
// rv32m_execute: iterative RV32M multiply/divide execute unit.
//   CLK, RST        clock, synchronous active-high reset
//   decode_execute  op select, signedness, lower_word, start
//   rs1_data        operand A / dividend
//   rs2_data        operand B / divisor
//   flush           abort in-flight op, no done pulse
//   busy            op in progress (MUL/DIV/FIXUP)
//   done            one-cycle pulse, result valid
//   result          held until the next accepted start
module rv32m_execute
  import rv32m_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  decode_execute_t decode_execute,
  input  logic [31:0]     rs1_data,
  input  logic [31:0]     rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [31:0]     result
);

  rv32m_exec_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;     // mul: {hi, lo} product; div: {rem, quo}
  logic [XLEN-1:0]   op_q, op_d;       // mul: multiplicand; div: divisor magnitude
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              is_mul_q, is_mul_d;
  logic              is_rem_q, is_rem_d;
  logic              lower_q, lower_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              op_valid_c, accept_c, a_signed_c, b_signed_c, a_neg_c, b_neg_c;
  logic [XLEN-1:0]   a_mag_c, b_mag_c;
  rv32m_special_t    special_c;
  logic [XLEN:0]     mul_sum_c;
  logic [2*XLEN-1:0] prod_fix_c;
  logic [XLEN-1:0]   div_rem_c, div_quo_c;

  // Operand decode: exactly one op, MULHSU treats rs1 signed and rs2 unsigned.
  always_comb begin
    op_valid_c = decode_execute.start &&
                 ({decode_execute.mul, decode_execute.div, decode_execute.rem} inside
                  {3'b100, 3'b010, 3'b001});
    accept_c   = op_valid_c && ((state_q == IDLE) || (state_q == DONE));
    a_signed_c = decode_execute.mul ? (decode_execute.signedness != usign_usign)
                                    : (decode_execute.signedness == sign_sign);
    b_signed_c = (decode_execute.signedness == sign_sign);
    a_neg_c    = a_signed_c && rs1_data[XLEN-1];
    b_neg_c    = b_signed_c && rs2_data[XLEN-1];
    a_mag_c    = a_neg_c ? -rs1_data : rs1_data;
    b_mag_c    = b_neg_c ? -rs2_data : rs2_data;
    special_c  = SPECIAL_NONE;
    if (!decode_execute.mul) begin
      if (rs2_data == '0)
        special_c = SPECIAL_DIV_ZERO;
      else if ((decode_execute.signedness == sign_sign) &&
               (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF))
        special_c = SPECIAL_OVERFLOW;
    end
  end

  // Shift-add multiply step: add multiplicand to the high half when lsb set.
  always_comb begin
    mul_sum_c  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? op_q : '0)};
    prod_fix_c = neg_res_q ? -acc_q : acc_q;
  end

  rv32m_radix2_divider u_div_step (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .quo_i     (acc_q[XLEN-1:0]),
    .divisor_i (op_q),
    .rem_o     (div_rem_c),
    .quo_o     (div_quo_c)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_mul_d  = is_mul_q;
    is_rem_d  = is_rem_q;
    lower_d   = lower_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (accept_c) begin
          is_mul_d  = decode_execute.mul;
          is_rem_d  = decode_execute.rem;
          lower_d   = decode_execute.lower_word;
          neg_res_d = a_neg_c ^ b_neg_c;
          neg_rem_d = a_neg_c;
          cnt_d     = '0;
          if (decode_execute.mul) begin
            acc_d   = {{XLEN{1'b0}}, b_mag_c};
            op_d    = a_mag_c;
            state_d = MUL;
            busy_d  = 1'b1;
          end else if (special_c == SPECIAL_DIV_ZERO) begin
            result_d = decode_execute.div ? 32'hFFFF_FFFF : rs1_data;
            state_d  = DONE;
            done_d   = 1'b1;
          end else if (special_c == SPECIAL_OVERFLOW) begin
            result_d = decode_execute.div ? 32'h8000_0000 : 32'h0000_0000;
            state_d  = DONE;
            done_d   = 1'b1;
          end else begin
            acc_d   = {{XLEN{1'b0}}, a_mag_c};
            op_d    = b_mag_c;
            state_d = DIV;
            busy_d  = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        acc_d = (state_q == MUL) ? {mul_sum_c, acc_q[XLEN-1:1]} : {div_rem_c, div_quo_c};
        // Counter stops at the last step rather than wrapping.
        if (cnt_q == CNT_W'(RV32M_ITERATIONS - 1))
          state_d = FIXUP;
        else
          cnt_d = cnt_q + CNT_W'(1);
      end
      FIXUP: begin
        if (is_mul_q)
          result_d = lower_q ? prod_fix_c[XLEN-1:0] : prod_fix_c[2*XLEN-1:XLEN];
        else if (is_rem_q)
          result_d = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        else
          result_d = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Flush wins over everything, including a same-cycle start.
    if (flush) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_mul_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      lower_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_mul_q  <= is_mul_d;
      is_rem_q  <= is_rem_d;
      lower_q   <= lower_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
